// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the ALU opcode scheduler.
// Optional statistics counters are enabled with ALU_SCHED_STATS_EN.
package alu_sched_pkg;

  // Scheduler phase: IDLE may issue, MC holds the decoder for a multi-cycle op.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MC   = 1'b1
  } sched_state_e;

  // Decoder select width used by the 32-bit datapath.
  localparam int OPW_DEFAULT = 4;

  // Opcodes 'hE and 'hF occupy the decoder for several cycles.
  localparam logic [15:0] MC_MASK_DEFAULT = 16'hC000;

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand_s;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = IW'((int'(ptr) + i) % NREQ);
      if (!valid && req[cand_s]) begin
        valid       = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// ALU opcode decoder scheduler: shares one decoder among NREQ requesters
// with round-robin arbitration and holds the enable for multi-cycle ops.
// Define ALU_SCHED_STATS_EN to add issue_cnt / mc_stall_cnt outputs.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int                  NREQ    = 4,
  parameter int                  OPW     = OPW_DEFAULT,
  parameter int                  MC_LAT  = 3,
  parameter logic [(2**OPW)-1:0] MC_MASK = MC_MASK_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*OPW-1:0]     op_i,
  output logic [NREQ-1:0]         gnt,
  output logic                    dec_en,
  output logic [OPW-1:0]          dec_sel,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]             issue_cnt,
  output logic [15:0]             mc_stall_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  sched_state_e  state_r, state_next_s;
  logic [IW-1:0] rr_ptr_r, rr_ptr_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;

  logic [NREQ-1:0] gnt_r, gnt_next_s;
  logic            dec_en_r, dec_en_next_s;
  logic [OPW-1:0]  dec_sel_r, dec_sel_next_s;
  logic            busy_r, busy_next_s;
  logic            done_r, done_next_s;
  logic [IW-1:0]   done_id_r, done_id_next_s;

  logic [NREQ-1:0] arb_gnt_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_valid_s;
  logic [OPW-1:0]  op_sel_s;
  logic            op_is_mc_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Opcode of the current winner and whether it occupies the decoder for several cycles.
  always_comb begin
    op_sel_s   = op_i[int'(arb_idx_s)*OPW +: OPW];
    op_is_mc_s = MC_MASK[op_sel_s];
  end

  // Next-state and next-output logic; held values default to their current registers.
  always_comb begin
    state_next_s   = state_r;
    rr_ptr_next_s  = rr_ptr_r;
    cnt_next_s     = cnt_r;
    gnt_next_s     = '0;
    dec_en_next_s  = 1'b0;
    dec_sel_next_s = dec_sel_r;
    busy_next_s    = 1'b0;
    done_next_s    = 1'b0;
    done_id_next_s = done_id_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          gnt_next_s     = arb_gnt_s;
          dec_en_next_s  = 1'b1;
          dec_sel_next_s = op_sel_s;
          done_id_next_s = arb_idx_s;
          if (arb_idx_s == LAST_IDX) begin
            rr_ptr_next_s = '0;
          end else begin
            rr_ptr_next_s = arb_idx_s + IDX_ONE;
          end
          if (op_is_mc_s) begin
            busy_next_s  = 1'b1;
            cnt_next_s   = CNT_LOAD;
            state_next_s = MC;
          end else begin
            done_next_s  = 1'b1;
          end
        end else begin
          dec_en_next_s = 1'b0;
        end
      end
      MC: begin
        // Requests are ignored here; the decoder stays on the in-flight op.
        dec_en_next_s = 1'b1;
        if (cnt_r == CNT_ONE) begin
          done_next_s  = 1'b1;
          cnt_next_s   = '0;
          state_next_s = IDLE;
        end else begin
          busy_next_s  = 1'b1;
          cnt_next_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // FSM state, round-robin pointer and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_next_s;
      rr_ptr_r <= rr_ptr_next_s;
      cnt_r    <= cnt_next_s;
    end
  end

  // Output registers; a reset drops any op in flight without replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r     <= '0;
      dec_en_r  <= 1'b0;
      dec_sel_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= '0;
    end else begin
      gnt_r     <= gnt_next_s;
      dec_en_r  <= dec_en_next_s;
      dec_sel_r <= dec_sel_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      done_id_r <= done_id_next_s;
    end
  end

  assign gnt     = gnt_r;
  assign dec_en  = dec_en_r;
  assign dec_sel = dec_sel_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] issue_cnt_r;
  logic [15:0] mc_stall_cnt_r;

  // Grant count and count of multi-cycle cycles that held off a pending request; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r    <= 16'h0000;
      mc_stall_cnt_r <= 16'h0000;
    end else begin
      if ((state_r == IDLE) && arb_valid_s) begin
        issue_cnt_r <= issue_cnt_r + 16'h0001;
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end
      if ((state_r == MC) && (|req)) begin
        mc_stall_cnt_r <= mc_stall_cnt_r + 16'h0001;
      end else begin
        mc_stall_cnt_r <= mc_stall_cnt_r;
      end
    end
  end

  assign issue_cnt    = issue_cnt_r;
  assign mc_stall_cnt = mc_stall_cnt_r;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed steps plus random
// traffic compared against a cycle-level behavioural model.
module tb_alu_op_scheduler;

  localparam int          NREQ    = 4;
  localparam int          OPW     = 4;
  localparam int          MC_LAT  = 3;
  localparam logic [15:0] MC_MASK = 16'hC000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_i;
  logic [3:0]  gnt;
  logic        dec_en;
  logic [3:0]  dec_sel;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] issue_cnt;
  logic [15:0] mc_stall_cnt;
`endif

  alu_op_scheduler #(
    .NREQ(NREQ), .OPW(OPW), .MC_LAT(MC_LAT), .MC_MASK(MC_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_i(op_i),
    .gnt(gnt), .dec_en(dec_en), .dec_sel(dec_sel), .busy(busy),
    .done(done), .done_id(done_id)
`ifdef ALU_SCHED_STATS_EN
    , .issue_cnt(issue_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: next requester to favour, and decoder cycles left for the op shown.
  int         m_ptr;
  int         m_left;
  logic [3:0] e_gnt;
  logic       e_en;
  logic [3:0] e_sel;
  logic [1:0] e_id;
  int         e_issue;
  int         e_stall;

  logic       pending [NREQ];
  logic [3:0] pend_op [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_left  = 0;
    e_gnt   = 4'b0000;
    e_en    = 1'b0;
    e_sel   = 4'h0;
    e_id    = 2'd0;
    e_issue = 0;
    e_stall = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [15:0] ops);
    int w;
    logic [3:0] op;
    if (m_left > 1) begin
      m_left--;
      e_gnt = 4'b0000;
      e_en  = 1'b1;
      if (r != 4'b0000) e_stall++;
    end else begin
      w = -1;
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (w < 0 && r[c]) w = c;
      end
      if (w >= 0) begin
        op       = ops[w*OPW +: OPW];
        e_gnt    = 4'b0000;
        e_gnt[w] = 1'b1;
        e_en     = 1'b1;
        e_sel    = op;
        e_id     = 2'(w);
        m_ptr    = (w + 1) % NREQ;
        m_left   = MC_MASK[op] ? MC_LAT : 1;
        e_issue++;
      end else begin
        m_left = 0;
        e_gnt  = 4'b0000;
        e_en   = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    chk({tag, ".dec_en"},  32'(dec_en),  32'(e_en));
    chk({tag, ".dec_sel"}, 32'(dec_sel), 32'(e_sel));
    chk({tag, ".busy"},    32'(busy),    32'(m_left > 1));
    chk({tag, ".done"},    32'(done),    32'(m_left == 1));
    chk({tag, ".done_id"}, 32'(done_id), 32'(e_id));
`ifdef ALU_SCHED_STATS_EN
    chk({tag, ".issue_cnt"},    32'(issue_cnt),    32'(e_issue % 65536));
    chk({tag, ".mc_stall_cnt"}, 32'(mc_stall_cnt), 32'(e_stall % 65536));
`endif
  endtask

  // One clock: drive inputs just after an edge, advance the model, check after the next edge.
  task automatic cycle(input string tag, input logic [3:0] r, input logic [15:0] ops);
    req  = r;
    op_i = ops;
    model_step(r, ops);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    op_i  = 16'h1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  r;
    logic [15:0] ops;
    logic [3:0]  exp_rr;

    // Reset with all requests high; outputs must be zero.
    do_reset();
    chk("reset_gnt_zero", 32'(gnt), 32'd0);

    // Four requesters, single-cycle op 'h1: rotating grant with done each cycle.
    for (int k = 0; k < 5; k++) begin
      cycle("rr4", 4'hF, 16'h1111);
      exp_rr = 4'b0001 << (k % 4);
      chk("rr4_seq", 32'(gnt), 32'(exp_rr));
      chk("rr4_done", 32'(done), 32'd1);
    end

    // Multi-cycle op 'hE from req0 (ptr now 1, only req0 asks).
    cycle("mc1", 4'b0001, 16'h000E);
    chk("mc1_busy", 32'(busy), 32'd1);
    cycle("mc2", 4'b0000, 16'h000E);
    chk("mc2_en", 32'(dec_en), 32'd1);
    cycle("mc3", 4'b0000, 16'h000E);
    chk("mc3_done", 32'(done), 32'd1);
    chk("mc3_sel", 32'(dec_sel), 32'hE);
    cycle("mc_idle", 4'b0000, 16'h000E);
    chk("mc_idle_en", 32'(dec_en), 32'd0);

    // Move pointer to 2 with req1, then req=1010 must wrap: 1000 then 0010.
    cycle("ptr2", 4'b0010, 16'h2222);
    cycle("wrap_a", 4'b1010, 16'h2222);
    chk("wrap_a_gnt", 32'(gnt), 32'b1000);
    cycle("wrap_b", 4'b0010, 16'h2222);
    chk("wrap_b_gnt", 32'(gnt), 32'b0010);

    // Lone requester 2 is granted every cycle.
    for (int k = 0; k < 3; k++) begin
      cycle("solo2", 4'b0100, 16'h0300);
      chk("solo2_gnt", 32'(gnt), 32'b0100);
    end

    // Random traffic; requesters hold until granted with a stable opcode.
    for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && ($urandom_range(0, 2) == 0)) begin
          pending[i] = 1'b1;
          pend_op[i] = 4'($urandom_range(0, 15));
        end
      end
      r   = 4'b0000;
      ops = 16'($urandom());
      for (int i = 0; i < NREQ; i++) begin
        r[i] = pending[i];
        if (pending[i]) ops[i*OPW +: OPW] = pend_op[i];
      end
      cycle("rand", r, ops);
      for (int i = 0; i < NREQ; i++) begin
        if (e_gnt[i]) pending[i] = 1'b0;
      end
    end

    // Asynchronous reset during the second multi-cycle cycle drops the op.
    do_reset();
    @(posedge clk);
    #1;
    cycle("rmc1", 4'b0001, 16'h000F);
    cycle("rmc2", 4'b0000, 16'h000F);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_en", 32'(dec_en), 32'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    // Pointer must be back at 0: req=1001 picks req0, not req3.
    cycle("rst_ptr", 4'b1001, 16'h5005);
    chk("rst_ptr_gnt", 32'(gnt), 32'b0001);

`ifdef ALU_SCHED_STATS_EN
    // Five single-cycle issues, then one multi-cycle op with requests pending.
    do_reset();
    for (int k = 0; k < 5; k++) cycle("st_sc", 4'hF, 16'h1111);
    cycle("st_mc0", 4'hF, 16'h11E1);
    cycle("st_mc1", 4'b1101, 16'h11E1);
    cycle("st_mc2", 4'b1101, 16'h11E1);
    chk("stats_issue", 32'(issue_cnt), 32'd6);
    chk("stats_stall", 32'(mc_stall_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
